// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-serial memory arbiter: FSM states, access size
// codes and transfer lengths.
package mem_arbiter_pkg;

    localparam int LEN_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IF_RD  = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_MEM_WR = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } size_e;

    localparam logic [LEN_W-1:0] IF_LEN = 3'd4;

    // The reserved size code behaves as a full word.
    function automatic logic [LEN_W-1:0] size_to_len(input logic [1:0] size);
        logic [LEN_W-1:0] len;
        case (size)
            SIZE_B:  len = 3'd1;
            SIZE_H:  len = 3'd2;
            default: len = 3'd4;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte sequencer: walks the byte addresses of one transfer and tracks which read
// bytes have actually been captured, so a stall replays from the right byte.
module mem_byte_seq
    import mem_arbiter_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      addr_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             wr_i,
    input  logic             step_i,
    input  logic             stall_i,
    output logic [31:0]      addr_o,
    output logic             issue_o,
    output logic [1:0]       idx_o,
    output logic             cap_o,
    output logic [1:0]       cap_idx_o,
    output logic             last_o
);

    logic [31:0]      base_q;
    logic [LEN_W-1:0] len_q;
    logic             wr_q;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [LEN_W-1:0] issue_idx;
    logic [LEN_W-1:0] last_idx;

    // For reads cnt_q counts captured bytes and pend_q marks a byte in flight.
    assign issue_idx = cnt_q + {{(LEN_W-1){1'b0}}, pend_q};
    assign last_idx  = len_q - 1'b1;
    assign issue_o   = issue_idx < len_q;
    assign addr_o    = base_q + {{(32-LEN_W){1'b0}}, issue_idx};
    assign idx_o     = issue_idx[1:0];
    assign cap_o     = step_i && pend_q && !wr_q;
    assign cap_idx_o = cnt_q[1:0];
    assign last_o    = step_i && (cnt_q == last_idx) && (wr_q || pend_q);

    always_comb begin
        cnt_d  = cnt_q;
        pend_d = pend_q;
        if (start_i) begin
            cnt_d  = '0;
            pend_d = 1'b0;
        end else if (step_i) begin
            if (wr_q) begin
                if (issue_o) cnt_d = cnt_q + 1'b1;
            end else begin
                if (pend_q) cnt_d = cnt_q + 1'b1;
                pend_d = issue_o;
            end
        end else if (stall_i) begin
            // The byte in flight arrives while frozen and is lost; re-issue it.
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            base_q <= '0;
            len_q  <= '0;
            wr_q   <= 1'b0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            if (start_i) begin
                base_q <= addr_i;
                len_q  <= len_i;
                wr_q   <= wr_i;
            end
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between instruction fetch and load/store onto a byte-wide RAM with a
// one-cycle read latency. Load/store has priority; transfers are never preempted.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_req_in,
    input  logic [31:0] if_addr_in,
    input  logic        if_flush_in,
    output logic        if_done_out,
    output logic [31:0] if_data_out,
    input  logic        mem_req_in,
    input  logic        mem_wr_in,
    input  logic [31:0] mem_addr_in,
    input  logic [1:0]  mem_size_in,
    input  logic [31:0] mem_wdata_in,
    output logic        mem_done_out,
    output logic [31:0] mem_rdata_out,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a_out,
    output logic        ram_wr_out
);

    state_e           state_q, state_d;
    logic             is_if_q, is_if_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      data_q, data_d;
    logic             xfer, step, stall, start, done_cycle;
    logic [31:0]      start_addr;
    logic [LEN_W-1:0] start_len;
    logic             start_wr;
    logic [31:0]      seq_addr;
    logic             seq_issue, seq_cap, seq_last;
    logic [1:0]       seq_idx, seq_cap_idx;

    assign xfer  = (state_q == ST_IF_RD) || (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);
    assign step  = xfer && rdy_in;
    assign stall = xfer && !rdy_in;

    assign start_addr = mem_req_in ? mem_addr_in : if_addr_in;
    assign start_len  = mem_req_in ? size_to_len(mem_size_in) : IF_LEN;
    assign start_wr   = mem_req_in && mem_wr_in;

    mem_byte_seq u_seq (
        .clk_i     (clk_in),
        .rst_i     (rst_in),
        .start_i   (start),
        .addr_i    (start_addr),
        .len_i     (start_len),
        .wr_i      (start_wr),
        .step_i    (step),
        .stall_i   (stall),
        .addr_o    (seq_addr),
        .issue_o   (seq_issue),
        .idx_o     (seq_idx),
        .cap_o     (seq_cap),
        .cap_idx_o (seq_cap_idx),
        .last_o    (seq_last)
    );

    always_comb begin
        state_d = state_q;
        is_if_d = is_if_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        start   = 1'b0;
        if (seq_cap) data_d[{seq_cap_idx, 3'b000} +: 8] = ram_din;
        case (state_q)
            ST_IDLE: begin
                if (rdy_in && mem_req_in) begin
                    start   = 1'b1;
                    state_d = mem_wr_in ? ST_MEM_WR : ST_MEM_RD;
                    is_if_d = 1'b0;
                    wdata_d = mem_wdata_in;
                    data_d  = '0;
                end else if (rdy_in && if_req_in && !if_flush_in) begin
                    start   = 1'b1;
                    state_d = ST_IF_RD;
                    is_if_d = 1'b1;
                    data_d  = '0;
                end
            end
            ST_IF_RD: begin
                if (rdy_in && if_flush_in) state_d = ST_IDLE;
                else if (seq_last)         state_d = ST_DONE;
            end
            ST_MEM_RD, ST_MEM_WR: begin
                if (seq_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (rdy_in) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            is_if_q <= 1'b0;
            wdata_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            is_if_q <= is_if_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
        end
    end

    // Outputs decode registered state only, so reset clears them immediately.
    assign ram_wr_out    = (state_q == ST_MEM_WR) && rdy_in && seq_issue;
    assign ram_a_out     = (xfer && seq_issue) ? seq_addr : '0;
    assign ram_dout      = ram_wr_out ? wdata_q[{seq_idx, 3'b000} +: 8] : '0;
    assign done_cycle    = (state_q == ST_DONE) && rdy_in;
    assign if_done_out   = done_cycle && is_if_q;
    assign mem_done_out  = done_cycle && !is_if_q;
    assign if_data_out   = if_done_out ? data_q : '0;
    assign mem_rdata_out = mem_done_out ? data_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transfers compared against a transaction-level memory model.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        if_req_in = 1'b0;
    logic [31:0] if_addr_in = '0;
    logic        if_flush_in = 1'b0;
    logic        if_done_out;
    logic [31:0] if_data_out;
    logic        mem_req_in = 1'b0;
    logic        mem_wr_in = 1'b0;
    logic [31:0] mem_addr_in = '0;
    logic [1:0]  mem_size_in = '0;
    logic [31:0] mem_wdata_in = '0;
    logic        mem_done_out;
    logic [31:0] mem_rdata_out;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a_out;
    logic        ram_wr_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  ram     [0:255];
    logic [7:0]  ref_mem [0:255];
    logic [39:0] wr_log  [$];

    mem_arbiter dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .if_req_in     (if_req_in),
        .if_addr_in    (if_addr_in),
        .if_flush_in   (if_flush_in),
        .if_done_out   (if_done_out),
        .if_data_out   (if_data_out),
        .mem_req_in    (mem_req_in),
        .mem_wr_in     (mem_wr_in),
        .mem_addr_in   (mem_addr_in),
        .mem_size_in   (mem_size_in),
        .mem_wdata_in  (mem_wdata_in),
        .mem_done_out  (mem_done_out),
        .mem_rdata_out (mem_rdata_out),
        .ram_din       (ram_din),
        .ram_dout      (ram_dout),
        .ram_a_out     (ram_a_out),
        .ram_wr_out    (ram_wr_out)
    );

    always #5 clk_in = ~clk_in;

    // Byte RAM with one-cycle read latency, aliased on the low 8 address bits.
    always @(posedge clk_in) begin
        ram_din <= ram[ram_a_out[7:0]];
        if (ram_wr_out) ram[ram_a_out[7:0]] <= ram_dout;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int size_len(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < n; i++) w[8*i +: 8] = ref_mem[8'(a + 32'(i))];
        return w;
    endfunction

    // One transfer; cycle 0 is the cycle the request is first presented.
    // rdy_in is low for cycles st_s .. st_s+st_l-1.
    task automatic run_xfer(input bit is_mem, input bit wr, input logic [31:0] addr,
                            input logic [1:0] size, input logic [31:0] wdata,
                            input int st_s, input int st_l);
        int n, base_lat, exp_lat, done_at, done_cnt, wrong_done, stall_wr, both, total;
        bit rd;
        logic [31:0] exp_data, got_data;
        n        = is_mem ? size_len(size) : 4;
        rd       = !(is_mem && wr);
        base_lat = rd ? n + 2 : n + 1;
        exp_lat  = base_lat;
        if (st_l > 0 && st_s <= base_lat) begin
            exp_lat = base_lat + st_l;
            // A stall after a read address went out loses that byte.
            if (rd && st_s >= 2 && st_s <= n + 1) exp_lat = exp_lat + 1;
        end
        exp_data = ref_word(addr, n);
        wr_log.delete();
        done_at = -1; done_cnt = 0; wrong_done = 0; stall_wr = 0; both = 0;
        got_data = '0;
        total = exp_lat + 4;
        @(posedge clk_in); #1;
        if (is_mem) begin
            mem_req_in = 1'b1; mem_wr_in = wr; mem_addr_in = addr;
            mem_size_in = size; mem_wdata_in = wdata;
        end else begin
            if_req_in = 1'b1; if_addr_in = addr;
        end
        for (int c = 0; c < total; c++) begin
            if (c > 0) begin @(posedge clk_in); #1; end
            if (done_at >= 0 && c == done_at + 1) begin
                mem_req_in = 1'b0; if_req_in = 1'b0;
            end
            rdy_in = !(st_l > 0 && c >= st_s && c < st_s + st_l);
            @(negedge clk_in);
            if (!rdy_in && ram_wr_out) stall_wr++;
            if (if_done_out && mem_done_out) both++;
            if (is_mem ? if_done_out : mem_done_out) wrong_done++;
            if (is_mem ? mem_done_out : if_done_out) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at  = c;
                    got_data = is_mem ? mem_rdata_out : if_data_out;
                    check_val("addr_in_done", ram_a_out, 32'h0);
                end
            end
            if (ram_wr_out) wr_log.push_back({ram_a_out, ram_dout});
        end
        mem_req_in = 1'b0; if_req_in = 1'b0; rdy_in = 1'b1;
        check_val("latency", done_at, exp_lat);
        check_val("done_pulses", done_cnt, 1);
        check_val("other_done", wrong_done, 0);
        check_val("stall_wr", stall_wr, 0);
        check_val("excl_done", both, 0);
        if (!rd) begin
            check_val("wr_count", wr_log.size(), n);
            for (int i = 0; i < n && i < wr_log.size(); i++) begin
                check_val("wr_addr", wr_log[i][39:8], addr + 32'(i));
                check_val("wr_data", 32'(wr_log[i][7:0]), 32'(wdata[8*i +: 8]));
            end
            for (int i = 0; i < n; i++) ref_mem[8'(addr + 32'(i))] = wdata[8*i +: 8];
        end else begin
            check_val("rdata", got_data, exp_data);
            check_val("rd_no_write", wr_log.size(), 0);
        end
        $display("xfer %s addr=%08h n=%0d stall=%0d@%0d lat=%0d data=%08h",
                 !is_mem ? "IF " : wr ? "ST " : "LD ", addr, n, st_l, st_s, done_at,
                 rd ? got_data : wdata);
    endtask

    initial begin
        logic [31:0] v, wd, mdata, idata, exp_if;
        int mem_at, if_at, fstart, cnt_done, cnt_wr;

        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            ram[i] = v[7:0];
            ref_mem[i] = v[7:0];
        end

        // Reset state
        #1;
        check_val("rst_addr", ram_a_out, 32'h0);
        check_val("rst_wr", 32'(ram_wr_out), 32'h0);
        check_val("rst_done", {30'h0, if_done_out, mem_done_out}, 32'h0);
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;

        // Fetch of a known instruction word
        ram[8'h00] = 8'h13; ram[8'h01] = 8'h00; ram[8'h02] = 8'h00; ram[8'h03] = 8'h93;
        ref_mem[8'h00] = 8'h13; ref_mem[8'h01] = 8'h00; ref_mem[8'h02] = 8'h00; ref_mem[8'h03] = 8'h93;
        run_xfer(1'b0, 1'b0, 32'h0000_1000, 2'b10, 32'h0, 0, 0);

        // Halfword store
        run_xfer(1'b1, 1'b1, 32'h0000_0020, 2'b01, 32'hABCD_1234, 0, 0);

        // Simultaneous requests: load wins, fetch follows after the DONE gap
        ram[8'h40] = 8'hFF; ref_mem[8'h40] = 8'hFF;
        exp_if = ref_word(32'h80, 4);
        mem_at = -1; if_at = -1; fstart = -1; mdata = '0; idata = '0;
        @(posedge clk_in); #1;
        mem_req_in = 1'b1; mem_wr_in = 1'b0; mem_addr_in = 32'h40; mem_size_in = 2'b00;
        if_req_in = 1'b1; if_addr_in = 32'h80;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) begin @(posedge clk_in); #1; end
            if (mem_at >= 0 && c == mem_at + 1) mem_req_in = 1'b0;
            if (if_at >= 0 && c == if_at + 1) if_req_in = 1'b0;
            @(negedge clk_in);
            if (mem_done_out && mem_at < 0) begin mem_at = c; mdata = mem_rdata_out; end
            if (if_done_out && if_at < 0) begin if_at = c; idata = if_data_out; end
            if (fstart < 0 && ram_a_out == 32'h80) fstart = c;
        end
        mem_req_in = 1'b0; if_req_in = 1'b0;
        check_val("arb_mem_cycle", mem_at, 3);
        check_val("arb_mem_data", mdata, 32'h0000_00FF);
        check_val("arb_fetch_start", fstart, 5);
        check_val("arb_if_cycle", if_at, 10);
        check_val("arb_if_data", idata, exp_if);
        $display("xfer ARB mem_done=%0d fetch_start=%0d if_done=%0d", mem_at, fstart, if_at);

        // Flush in cycle 2 of a fetch
        @(posedge clk_in); #1;
        if_req_in = 1'b1; if_addr_in = 32'h50;
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        if_flush_in = 1'b1;
        @(posedge clk_in); #1;
        if_flush_in = 1'b0; if_req_in = 1'b0;
        @(negedge clk_in);
        check_val("flush_idle_addr", ram_a_out, 32'h0);
        cnt_done = 0; cnt_wr = 0;
        for (int c = 0; c < 8; c++) begin
            if (if_done_out || mem_done_out) cnt_done++;
            if (ram_wr_out) cnt_wr++;
            @(negedge clk_in);
        end
        check_val("flush_no_done", cnt_done, 0);
        check_val("flush_no_wr", cnt_wr, 0);
        $display("xfer FLUSH addr=00000050 dones=%0d writes=%0d", cnt_done, cnt_wr);
        run_xfer(1'b0, 1'b0, 32'h0000_0050, 2'b10, 32'h0, 0, 0);

        // Stall during a word load
        run_xfer(1'b1, 1'b0, 32'h0000_0060, 2'b10, 32'h0, 3, 2);

        // Reserved size code and address wrap-around
        run_xfer(1'b1, 1'b1, 32'h0000_0070, 2'b11, 32'hDEAD_BEEF, 0, 0);
        run_xfer(1'b1, 1'b1, 32'hFFFF_FFFE, 2'b10, 32'hCAFE_F00D, 0, 0);
        run_xfer(1'b1, 1'b0, 32'hFFFF_FFFE, 2'b10, 32'h0, 0, 0);

        // Reset in the middle of a word store
        wd = $urandom;
        @(posedge clk_in); #1;
        mem_req_in = 1'b1; mem_wr_in = 1'b1; mem_addr_in = 32'h30;
        mem_size_in = 2'b10; mem_wdata_in = wd;
        @(posedge clk_in); #1;
        @(posedge clk_in); #2;
        rst_in = 1'b1;
        #1;
        check_val("rst_mid_wr", 32'(ram_wr_out), 32'h0);
        check_val("rst_mid_addr", ram_a_out, 32'h0);
        check_val("rst_mid_dout", 32'(ram_dout), 32'h0);
        mem_req_in = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        ref_mem[8'h30] = wd[7:0];
        cnt_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_in);
            if (if_done_out || mem_done_out) cnt_done++;
        end
        check_val("rst_no_done", cnt_done, 0);
        $display("xfer RESET addr=00000030 dones=%0d", cnt_done);
        run_xfer(1'b1, 1'b0, 32'h0000_0030, 2'b10, 32'h0, 0, 0);

        // Randomized transfers with optional stall windows
        for (int t = 0; t < 40; t++) begin
            bit          is_mem, wr;
            logic [31:0] a, d;
            logic [1:0]  sz;
            int          s, l;
            is_mem = ($urandom_range(0, 2) != 0);
            wr     = is_mem && ($urandom_range(0, 1) == 1);
            a      = $urandom;
            d      = $urandom;
            sz     = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                s = $urandom_range(0, 6);
                l = $urandom_range(1, 3);
            end else begin
                s = 0;
                l = 0;
            end
            run_xfer(is_mem, wr, a, sz, d, s, l);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
